lipsi_program_loader: RTL
=========================

Name: lipsi_program_loader

Overview:
- Writer side of the Lipsi instruction memory. The core only reads program bytes; this block receives a framed byte stream and writes it into instruction memory.
- Holds the core in reset until a frame has loaded and its checksum verifies, then releases it.
- Frame format: SYNC, LEN, LEN data bytes, CSUM.
- After a good load, appends the exit opcode 0xFF so the core halts at the end of the program.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- HALT_OP, 8'hFF, terminator written after the program (the core's exit opcode).
- TIMEOUT, 1000, maximum idle cycles between bytes inside a frame; 0 disables the timeout.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low; asserted when 0.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte; a transfer occurs on a rising edge with in_valid & in_ready.
- mem_we  out  1  instruction-memory write strobe, one cycle per byte.
- mem_addr  out  8  write address.
- mem_wdata  out  8  write data.
- core_reset  out  1  active-high hold for the Lipsi core.
- done  out  1  load verified; core running.
- error  out  1  checksum mismatch or timeout.
- byte_count  out  9  data bytes written in the current frame (0..256).

Behaviour:
- Reset (reset==0, asynchronous), all outputs as follows:
  - state=IDLE, core_reset=1, done=0, error=0, mem_we=0, mem_addr=0, mem_wdata=0, byte_count=0.
  - sum=0, idle counter=0.
- in_ready is combinational from state: 1 in every state except TERM.
- States:
  - IDLE: a SYNC_BYTE transfer goes to LEN. Any other byte is accepted and dropped.
  - LEN: transfer latches len = in_data, with 0 meaning 256. Clears sum and byte_count. Goes to DATA.
  - DATA: each transfer registers mem_we=1, mem_addr=byte_count[7:0], mem_wdata=in_data. The write is visible the cycle after the accepting edge (1-cycle latency). Then sum += in_data (mod 256) and byte_count++. The transfer that makes byte_count==len goes to CSUM.
  - CSUM: transfer compares in_data with sum.
    - Equal and len<256: go to TERM.
    - Equal and len==256: go to DONE (no room for a terminator).
    - Not equal: go to ERROR.
  - TERM: exactly one cycle. mem_we=1, mem_addr=len[7:0], mem_wdata=HALT_OP, in_ready=0. Then go to DONE.
  - DONE: done=1, core_reset=0. A SYNC_BYTE transfer goes to LEN with core_reset=1 and done=0 on the same edge. Other bytes are dropped.
  - ERROR: error=1, core_reset=1. A SYNC_BYTE transfer goes to LEN and clears error. Other bytes are dropped.
- mem_we is 1 only in the cycle after a DATA transfer and in TERM; otherwise 0. mem_addr and mem_wdata hold their last values when mem_we=0.
- Idle timeout:
  - Applies in LEN, DATA and CSUM only.
  - The counter increments each cycle without a transfer and clears on each transfer.
  - Reaching TIMEOUT forces ERROR. Partially written memory is left as is.
  - TIMEOUT=0 disables the timeout. The counter is held at 0 outside LEN, DATA and CSUM.
- SYNC_BYTE in LEN, DATA or CSUM is treated as ordinary data. There is no resync mid-frame.
- Reset asserted mid-frame aborts the load immediately. core_reset is 1 and memory contents are undefined for the core.
- Addresses wrap at 8 bits. byte_count is 9 bits so it can reach 256.

Test Plan:
- Frame A5,03,C7,05,FF,CB with in_valid held high:
  - writes addr0=C7, addr1=05, addr2=FF, then TERM writes addr3=FF;
  - done=1 and core_reset=0 one cycle after TERM; byte_count=3.
- Same frame with CSUM=CC -> error=1, core_reset stays 1, no TERM write. A following A5,01,10,10 -> error clears, addr0=10, addr1=FF, done=1.
- LEN=00 with 256 bytes of value 01 and CSUM=00 -> 256 writes to addr 00..FF, no terminator write, done=1, byte_count=256.
- Leading bytes 00,FF,12 before A5 -> all dropped, no mem_we. A5 inside the data is written as data.
- TIMEOUT=10: send A5,04,11, then 10 idle cycles -> error=1 exactly at the 10th idle cycle; addr0=11 remains written.
- Assert reset during DATA after 2 bytes -> immediately core_reset=1, done=0, mem_we=0. After release, state is IDLE and bytes other than A5 are ignored.

Source files
------------

// File: rtl/lipsi_program_loader.sv
// ---------------------------------------------------------------------------
// lipsi_program_loader
//
// Writer side of the Lipsi instruction memory. A framed byte stream
//     SYNC, LEN, LEN data bytes, CSUM
// is written into instruction memory starting at address 0. The Lipsi core
// is held in reset until a frame has loaded and its 8-bit additive checksum
// matches. When the program is shorter than 256 bytes, the halt opcode is
// written directly after it so the core stops at the end of the program.
//
// Ports
//     clk        - single clock, rising edge
//     reset      - asynchronous, active-low
//     in_valid   - stream byte available on in_data
//     in_data    - stream byte
//     in_ready   - loader accepts a byte (low only while writing the halt op)
//     mem_we     - instruction-memory write strobe, one cycle per byte
//     mem_addr   - write address (holds its value while mem_we is low)
//     mem_wdata  - write data (holds its value while mem_we is low)
//     core_reset - active-high hold for the Lipsi core
//     done       - program loaded and verified, core running
//     error      - checksum mismatch or inter-byte timeout
//     byte_count - data bytes written in the current frame (0..256)
// ---------------------------------------------------------------------------
module lipsi_program_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter logic [7:0] HALT_OP   = 8'hFF,
    parameter int         TIMEOUT   = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       core_reset,
    output logic       done,
    output logic       error,
    output logic [8:0] byte_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_TERM,
        S_DONE,
        S_ERROR
    } state_t;

    // The idle counter only has to reach TIMEOUT-1: the idle cycle that would
    // take it to TIMEOUT is the one that raises the error.
    localparam int             IDLE_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit             TIMEOUT_EN = (TIMEOUT > 0);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT =
        (TIMEOUT > 0) ? IDLE_W'(TIMEOUT - 1) : '0;

    state_t              state;
    logic [8:0]          len;
    logic [7:0]          sum;
    logic [IDLE_W-1:0]   idle_cnt;

    logic                xfer;
    logic                in_frame;
    logic [8:0]          len_next;
    logic [8:0]          count_next;

    // The only cycle the loader refuses input is the halt-op write.
    assign in_ready   = (state != S_TERM);
    assign xfer       = in_valid & in_ready;
    assign in_frame   = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
    // A length byte of zero encodes a full 256-byte program.
    assign len_next   = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
    assign count_next = byte_count + 9'd1;

    // Frame parser, memory write port and core hold. All outputs are
    // registered; the write strobe is a one-cycle pulse that defaults low and
    // is raised by a data transfer or by the halt-op write. The idle timeout
    // is evaluated after the state case: it can only fire on a cycle without
    // a transfer, where the case itself leaves the state alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            len        <= 9'd0;
            sum        <= 8'd0;
            idle_cnt   <= '0;
            byte_count <= 9'd0;
            mem_we     <= 1'b0;
            mem_addr   <= 8'd0;
            mem_wdata  <= 8'd0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            mem_we <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (xfer && (in_data == SYNC_BYTE)) begin
                        state <= S_LEN;
                    end
                end

                S_LEN: begin
                    if (xfer) begin
                        len        <= len_next;
                        sum        <= 8'd0;
                        byte_count <= 9'd0;
                        state      <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (xfer) begin
                        mem_we     <= 1'b1;
                        mem_addr   <= byte_count[7:0];
                        mem_wdata  <= in_data;
                        sum        <= sum + in_data;
                        byte_count <= count_next;
                        if (count_next == len) begin
                            state <= S_CSUM;
                        end
                    end
                end

                S_CSUM: begin
                    if (xfer) begin
                        if (in_data == sum) begin
                            if (len == 9'd256) begin
                                // Memory is full, there is no slot for the halt op.
                                state      <= S_DONE;
                                done       <= 1'b1;
                                core_reset <= 1'b0;
                            end else begin
                                state     <= S_TERM;
                                mem_we    <= 1'b1;
                                mem_addr  <= len[7:0];
                                mem_wdata <= HALT_OP;
                            end
                        end else begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end
                    end
                end

                S_TERM: begin
                    state      <= S_DONE;
                    done       <= 1'b1;
                    core_reset <= 1'b0;
                end

                S_DONE: begin
                    // A new frame puts the core back on hold right away.
                    if (xfer && (in_data == SYNC_BYTE)) begin
                        state      <= S_LEN;
                        done       <= 1'b0;
                        core_reset <= 1'b1;
                    end
                end

                S_ERROR: begin
                    if (xfer && (in_data == SYNC_BYTE)) begin
                        state <= S_LEN;
                        error <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Inter-byte timeout inside a frame. Partially written memory
            // is left as it is; the core stays held because done never rose.
            if (in_frame) begin
                if (xfer) begin
                    idle_cnt <= '0;
                end else if (TIMEOUT_EN) begin
                    if (idle_cnt == IDLE_LIMIT) begin
                        state      <= S_ERROR;
                        error      <= 1'b1;
                        core_reset <= 1'b1;
                        idle_cnt   <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

endmodule
